ws2812_chain_ctl: RTL and testbench
===================================

Name: ws2812_chain_ctl

Overview:
Parametrised WS2812/SK6812 frame controller.
- Holds per-LED colour words in an internal synchronous RAM. Each word also carries a next-address link, so LED order is a linked list.
- Walks the chain from START_ADDR and serialises each colour MSB-first to the downstream bit encoder through a bit_rdy/bit_done handshake.
- Ends each frame with a reset (latch) interval.
- Sits between the host byte-write path and the per-strip bit-timing encoder. Supports RGB (24-bit) or RGBW (32-bit) strips and guards against cyclic chains.

Parameters:
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W nodes
COLOR_BITS, 24, colour bits per LED; legal values 24 or 32
NBYTES, ceil((COLOR_BITS+ADDR_W)/8), bytes per RAM word (4 for 24/6, 5 for 32/6)
RST_CYCLES, 10000, clock cycles held in reset state (50 us at 200 MHz)
START_ADDR, 0, chain head address and chain terminator value

Ports:
clk_in  in  1  clock
rst_n_in  in  1  reset, asynchronous, active-low
wr_en_in  in  1  RAM write strobe
wr_addr_in  in  ADDR_W  RAM write address
wr_byte_en_in  in  NBYTES  per-byte write enables
wr_data_in  in  8  write byte, replicated to all byte lanes
frame_rdy_in  in  1  start-frame request (level, sampled each cycle)
bit_done_in  in  1  one-cycle pulse from encoder: current bit finished
bit_rdy_out  out  1  one-cycle pulse: bit_data_out valid, encoder to start bit
bit_data_out  out  1  current data bit; held until next bit_rdy_out
busy_out  out  1  high in any state other than IDLE
frame_done_out  out  1  one-cycle pulse on leaving RST

Behaviour:
- RAM word layout: colour in [COLOR_BITS-1:0]; next address in [COLOR_BITS+ADDR_W-1:COLOR_BITS]; remaining bits are don't-care.
- RAM access:
  - Byte i is written with wr_data_in when wr_en_in and wr_byte_en_in[i] are both high.
  - Read latency is 1 cycle.
  - Read and write to the same address in the same cycle returns the old data.
  - RAM contents are not reset.
- Reset: state IDLE; bit_rdy_out=0, bit_data_out=0, busy_out=0, frame_done_out=0; pending=0; node and bit counters cleared. Async assertion mid-frame aborts immediately.
- FSM:
  - IDLE: frame_rdy_in or pending -> RD_ADDR. Load cur_addr=START_ADDR and node_cnt=0; clear pending.
  - RD_ADDR: read cur_addr -> RD_DATA.
  - RD_DATA: load shift register with colour, next_addr from the link field, bit_cnt=0. Register bit_rdy_out=1 and bit_data_out=colour MSB -> SEND.
  - SEND, on bit_done_in:
    - If bit_cnt != COLOR_BITS-1: increment bit_cnt and shift; next cycle bit_rdy_out=1 with the next bit.
    - Else increment node_cnt. Go to RST if next_addr==START_ADDR or node_cnt==DEPTH-1 (cyclic-chain guard). Otherwise set cur_addr=next_addr and go to RD_ADDR.
  - RST: count RST_CYCLES cycles, then pulse frame_done_out=1 -> IDLE.
- Latency:
  - bit_done_in in cycle k -> bit_rdy_out in cycle k+1 within an LED.
  - bit_done_in in cycle k -> bit_rdy_out in cycle k+3 across an LED boundary.
  - frame_rdy_in in cycle k (IDLE) -> first bit_rdy_out in cycle k+3.
- Every bit_rdy_out is exactly one cycle wide. Exactly COLOR_BITS pulses are sent per node.
- bit_done_in is ignored outside SEND.
- frame_rdy_in high while busy_out=1 sets pending. The next frame starts in the cycle after frame_done_out with no new request. Further requests while pending is set are merged into it.
- Writes are allowed during a frame; a word already read is not re-read.

Optional Feature:
Macro WS2812_DIM_EN.
- Defined:
  - Adds input brightness_in[7:0], sampled on IDLE->RD_ADDR and held for the frame.
  - Each 8-bit colour channel c becomes (c*(brightness_in+1))>>8.
  - Adds one pipeline stage between RD_DATA and SEND; the k+3 latencies become k+4.
- Undefined: no port, no scaling, latencies as above.

Test Plan:
1. Chain 0->1->2->0 with colours FF0000, 00FF00, 0000FF; encoder returns bit_done 5 cycles after each bit_rdy -> 72 bit_rdy pulses carrying FF0000 00FF00 0000FF MSB-first, then frame_done_out exactly RST_CYCLES+1 cycles after the last bit_done.
2. Single node (node 0 links to 0), colour A5A5A5 -> 24 pulses 101001011010010110100101, busy_out high throughout, frame_done_out pulses once.
3. Cyclic chain 0->1->2->1 -> exactly 64 nodes (1536 bits) sent, then RST and frame_done_out; no hang.
4. frame_rdy_in pulsed during SEND of a 3-node frame -> after frame_done_out, IDLE for 1 cycle, then a second identical frame starts with no further request.
5. rst_n_in asserted mid-SEND -> bit_rdy_out, busy_out and bit_data_out go to 0 asynchronously; after release, frame_rdy_in restarts from node 0 bit 23.
6. WS2812_DIM_EN defined, brightness_in=7F, colour FF8040 -> transmitted bits encode 7F4020; first bit_rdy_out 4 cycles after frame_rdy_in.

Source files
------------

// File: rtl/ws2812_chain_ctl_if.sv
// ----------------------------------------------------------------------------
// ws2812_chain_ctl_if
// Bundles the host write path, the frame request and the bit-encoder
// handshake of ws2812_chain_ctl into one interface.
//
// Signals:
//   wr_en_in, wr_addr_in, wr_byte_en_in, wr_data_in : colour RAM byte writes
//   frame_rdy_in                                     : start-frame request (level)
//   bit_done_in                                      : encoder finished current bit
//   brightness_in                                    : global dim level (WS2812_DIM_EN only)
//   bit_rdy_out, bit_data_out                        : bit strobe and data to encoder
//   busy_out, frame_done_out                         : controller status
//
// Modports: master = host/encoder side, slave = controller side.
// Optional macro: WS2812_DIM_EN adds brightness_in.
// ----------------------------------------------------------------------------
interface ws2812_chain_ctl_if #(
    parameter int ADDR_W = 6,
    parameter int NBYTES = 4
);
    logic              wr_en_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [NBYTES-1:0] wr_byte_en_in;
    logic [7:0]        wr_data_in;
    logic              frame_rdy_in;
    logic              bit_done_in;
`ifdef WS2812_DIM_EN
    logic [7:0]        brightness_in;
`endif
    logic              bit_rdy_out;
    logic              bit_data_out;
    logic              busy_out;
    logic              frame_done_out;

    modport master (
`ifdef WS2812_DIM_EN
        output brightness_in,
`endif
        output wr_en_in, wr_addr_in, wr_byte_en_in, wr_data_in,
        output frame_rdy_in, bit_done_in,
        input  bit_rdy_out, bit_data_out, busy_out, frame_done_out
    );

    modport slave (
`ifdef WS2812_DIM_EN
        input  brightness_in,
`endif
        input  wr_en_in, wr_addr_in, wr_byte_en_in, wr_data_in,
        input  frame_rdy_in, bit_done_in,
        output bit_rdy_out, bit_data_out, busy_out, frame_done_out
    );
endinterface

// File: rtl/ws2812_chain_ctl.sv
// ----------------------------------------------------------------------------
// ws2812_chain_ctl
// WS2812/SK6812 frame controller. Colour words live in an internal RAM, each
// word carrying a link to the next LED, so LED order is a linked list that
// starts (and ends) at START_ADDR. Every frame walks the list, shifts each
// colour out MSB-first over a bit_rdy/bit_done handshake with the bit
// encoder, then holds a latch interval of RST_CYCLES clocks.
//
// Ports:
//   clk_in    : clock
//   rst_n_in  : asynchronous active-low reset
//   bus       : ws2812_chain_ctl_if.slave (RAM writes, frame request,
//               encoder handshake, status)
//
// RAM word: colour in [COLOR_BITS-1:0], link in
// [COLOR_BITS+ADDR_W-1:COLOR_BITS]; bits above are don't-care and not stored.
//
// Optional macro WS2812_DIM_EN: every 8-bit channel c is scaled to
// (c*(brightness+1))>>8 using brightness sampled at frame start; this adds
// one pipeline state between RAM read and the first bit of each LED.
// ----------------------------------------------------------------------------
module ws2812_chain_ctl #(
    parameter int ADDR_W     = 6,
    parameter int COLOR_BITS = 24,
    parameter int NBYTES     = (COLOR_BITS + ADDR_W + 7) / 8,
    parameter int RST_CYCLES = 10000,
    parameter int START_ADDR = 0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    ws2812_chain_ctl_if.slave   bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int USED_W = COLOR_BITS + ADDR_W;
    localparam int BCNT_W = $clog2(COLOR_BITS);
    localparam int RCNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_NODE = ADDR_W'(DEPTH - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(COLOR_BITS - 1);
    localparam logic [RCNT_W-1:0] RST_LAST  = RCNT_W'(RST_CYCLES - 1);

    // S_DIM is only entered when dimming is built in.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_DIM     = 3'd3,
        S_SEND    = 3'd4,
        S_RST     = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDR_W-1:0]       cur_addr_r, cur_addr_s;
    logic [ADDR_W-1:0]       next_addr_r, next_addr_s;
    logic [ADDR_W-1:0]       node_cnt_r, node_cnt_s;
    logic [BCNT_W-1:0]       bit_cnt_r, bit_cnt_s;
    logic [COLOR_BITS-1:0]   shift_r, shift_s;
    logic [RCNT_W-1:0]       rst_cnt_r, rst_cnt_s;
    logic                    pending_r, pending_s;
    logic                    bit_rdy_r, bit_rdy_s;
    logic                    bit_data_r, bit_data_s;
    logic                    busy_r, busy_s;
    logic                    frame_done_r, frame_done_s;
    logic                    rd_en_s;

    logic [USED_W-1:0]       mem_r [DEPTH];
    logic [USED_W-1:0]       rd_data_r;

`ifdef WS2812_DIM_EN
    logic [7:0]              bright_r, bright_s;

    // Scale each 8-bit channel by (brightness+1)/256; max product fits 16 bits.
    function automatic logic [COLOR_BITS-1:0] dim_scale(
        input logic [COLOR_BITS-1:0] color,
        input logic [7:0]            level
    );
        logic [15:0] prod;
        dim_scale = '0;
        for (int ch = 0; ch < COLOR_BITS / 8; ch++) begin
            prod = 16'(color[ch*8 +: 8]) * (16'(level) + 16'd1);
            dim_scale[ch*8 +: 8] = prod[15:8];
        end
    endfunction
`endif

    // Colour RAM: per-byte-lane writes, registered read, read-before-write.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < USED_W; i++) begin
            if (bus.wr_en_in && bus.wr_byte_en_in[i / 8]) begin
                mem_r[bus.wr_addr_in][i] <= bus.wr_data_in[i % 8];
            end
        end
        if (rd_en_s) begin
            rd_data_r <= mem_r[cur_addr_r];
        end
    end

    // Next-state and datapath decode for the chain walker.
    always_comb begin
        state_s      = state_r;
        cur_addr_s   = cur_addr_r;
        next_addr_s  = next_addr_r;
        node_cnt_s   = node_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        rst_cnt_s    = rst_cnt_r;
        pending_s    = pending_r;
        bit_rdy_s    = 1'b0;
        bit_data_s   = bit_data_r;
        frame_done_s = 1'b0;
        rd_en_s      = 1'b0;
`ifdef WS2812_DIM_EN
        bright_s     = bright_r;
`endif

        // Requests arriving mid-frame collapse into a single queued frame.
        if (busy_r && bus.frame_rdy_in) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        case (state_r)
            S_IDLE: begin
                if (bus.frame_rdy_in || pending_r) begin
                    state_s    = S_RD_ADDR;
                    cur_addr_s = START_A;
                    node_cnt_s = '0;
                    pending_s  = 1'b0;
`ifdef WS2812_DIM_EN
                    bright_s   = bus.brightness_in;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                rd_en_s = 1'b1;
                state_s = S_RD_DATA;
            end
            S_RD_DATA: begin
                next_addr_s = rd_data_r[COLOR_BITS +: ADDR_W];
                bit_cnt_s   = '0;
`ifdef WS2812_DIM_EN
                shift_s     = dim_scale(rd_data_r[COLOR_BITS-1:0], bright_r);
                state_s     = S_DIM;
`else
                shift_s     = rd_data_r[COLOR_BITS-1:0];
                bit_rdy_s   = 1'b1;
                bit_data_s  = rd_data_r[COLOR_BITS-1];
                state_s     = S_SEND;
`endif
            end
            S_DIM: begin
                bit_rdy_s  = 1'b1;
                bit_data_s = shift_r[COLOR_BITS-1];
                state_s    = S_SEND;
            end
            S_SEND: begin
                if (bus.bit_done_in) begin
                    if (bit_cnt_r != LAST_BIT) begin
                        bit_cnt_s  = bit_cnt_r + BCNT_W'(1);
                        shift_s    = {shift_r[COLOR_BITS-2:0], 1'b0};
                        bit_rdy_s  = 1'b1;
                        bit_data_s = shift_r[COLOR_BITS-2];
                    end else begin
                        node_cnt_s = node_cnt_r + ADDR_W'(1);
                        // node_cnt at DEPTH-1 means every address was visited:
                        // the list must loop, so stop here.
                        if ((next_addr_r == START_A) || (node_cnt_r == LAST_NODE)) begin
                            state_s   = S_RST;
                            rst_cnt_s = '0;
                        end else begin
                            cur_addr_s = next_addr_r;
                            state_s    = S_RD_ADDR;
                        end
                    end
                end else begin
                    state_s = S_SEND;
                end
            end
            S_RST: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_s      = S_IDLE;
                    frame_done_s = 1'b1;
                    rst_cnt_s    = '0;
                end else begin
                    rst_cnt_s = rst_cnt_r + RCNT_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r      <= S_IDLE;
            cur_addr_r   <= START_A;
            next_addr_r  <= START_A;
            node_cnt_r   <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            rst_cnt_r    <= '0;
            pending_r    <= 1'b0;
            bit_rdy_r    <= 1'b0;
            bit_data_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef WS2812_DIM_EN
            bright_r     <= 8'd0;
`endif
        end else begin
            state_r      <= state_s;
            cur_addr_r   <= cur_addr_s;
            next_addr_r  <= next_addr_s;
            node_cnt_r   <= node_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            rst_cnt_r    <= rst_cnt_s;
            pending_r    <= pending_s;
            bit_rdy_r    <= bit_rdy_s;
            bit_data_r   <= bit_data_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
`ifdef WS2812_DIM_EN
            bright_r     <= bright_s;
`endif
        end
    end

    assign bus.bit_rdy_out    = bit_rdy_r;
    assign bus.bit_data_out   = bit_data_r;
    assign bus.busy_out       = busy_r;
    assign bus.frame_done_out = frame_done_r;
endmodule

// File: tb/tb_ws2812_chain_ctl.sv
// ----------------------------------------------------------------------------
// tb_ws2812_chain_ctl
// Self-checking bench for ws2812_chain_ctl. A behavioural encoder answers
// every bit_rdy_out with bit_done_in after a fixed or random delay and logs
// bits and timing; a RAM image plus list walk gives the expected bit stream.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_chain_ctl;
    localparam int ADDR_W     = 6;
    localparam int COLOR_BITS = 24;
    localparam int NBYTES     = 4;
    localparam int RST_CYCLES = 37;
    localparam int DEPTH      = 64;
`ifdef WS2812_DIM_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk_in;
    logic rst_n_in;
    int   cyc;
    int   errors;
    int   checks;

    ws2812_chain_ctl_if #(.ADDR_W(ADDR_W), .NBYTES(NBYTES)) bus ();

    ws2812_chain_ctl #(
        .ADDR_W(ADDR_W), .COLOR_BITS(COLOR_BITS), .NBYTES(NBYTES),
        .RST_CYCLES(RST_CYCLES), .START_ADDR(0)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_in);
            cyc = cyc + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mem_model [DEPTH];
    bit          exp_bits[$];
`ifdef WS2812_DIM_EN
    logic [7:0]  bright_model;
`endif

    function automatic logic [23:0] model_colour(input logic [31:0] w);
        logic [23:0] c;
        c = w[23:0];
`ifdef WS2812_DIM_EN
        for (int ch = 0; ch < 3; ch++) begin
            c[ch*8 +: 8] = 8'((int'(w[ch*8 +: 8]) * (int'(bright_model) + 1)) / 256);
        end
`endif
        return c;
    endfunction

    // Walk the list from node 0 until a link returns to 0 or 64 nodes are out.
    function automatic void build_expected();
        int addr;
        logic [23:0] c;
        addr = 0;
        exp_bits.delete();
        for (int n = 0; n < DEPTH; n++) begin
            c = model_colour(mem_model[addr]);
            for (int b = 23; b >= 0; b--) exp_bits.push_back(c[b]);
            addr = int'(mem_model[addr][29:24]);
            if (addr == 0) break;
        end
    endfunction

    // ---------------- encoder model and monitor ----------------
    bit   q_bits[$];
    int   q_rdy[$];
    int   q_done[$];
    int   q_fd[$];
    logic q_fd_busy[$];
    int   enc_delay;
    bit   enc_rand;
    int   enc_cnt;
    logic prev_rdy;
    int   wide_rdy;

    initial begin
        bus.bit_done_in = 1'b0;
        enc_cnt  = 0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk_in);
            bus.bit_done_in = 1'b0;
            if (!rst_n_in) begin
                enc_cnt = 0;
            end else if (enc_cnt > 0) begin
                enc_cnt = enc_cnt - 1;
                if (enc_cnt == 0) begin
                    bus.bit_done_in = 1'b1;
                    q_done.push_back(cyc);
                end
            end
            if (bus.bit_rdy_out === 1'b1) begin
                if (prev_rdy) wide_rdy++;
                q_bits.push_back(bus.bit_data_out);
                q_rdy.push_back(cyc);
                enc_cnt = enc_rand ? int'($urandom_range(1, 6)) : enc_delay;
            end
            prev_rdy = (bus.bit_rdy_out === 1'b1);
            if (bus.frame_done_out === 1'b1) begin
                q_fd.push_back(cyc);
                q_fd_busy.push_back(bus.busy_out);
            end
        end
    end

    function automatic int count_mismatch(input int offset);
        int m;
        m = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            if (offset + i >= q_bits.size()) m++;
            else if (q_bits[offset + i] != exp_bits[i]) m++;
        end
        return m;
    endfunction

    // bit_done -> next bit_rdy must be 1 cycle inside an LED, 3(+pipe) across.
    function automatic int gap_errors(input int first, input int n);
        int bad;
        int want;
        bad = 0;
        for (int i = first; i < first + n - 1; i++) begin
            want = (((i - first + 1) % COLOR_BITS) == 0) ? (3 + PIPE) : 1;
            if (i + 1 >= q_rdy.size() || i >= q_done.size()) bad++;
            else if (q_rdy[i + 1] - q_done[i] != want) bad++;
        end
        return bad;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_capture();
        q_bits.delete(); q_rdy.delete(); q_done.delete();
        q_fd.delete(); q_fd_busy.delete();
        wide_rdy = 0;
    endtask

    task automatic write_bus(input int addr, input logic [3:0] be, input logic [7:0] data);
        @(negedge clk_in);
        bus.wr_en_in      = 1'b1;
        bus.wr_addr_in    = addr[5:0];
        bus.wr_byte_en_in = be;
        bus.wr_data_in    = data;
        for (int l = 0; l < 4; l++) if (be[l]) mem_model[addr][l*8 +: 8] = data;
        @(negedge clk_in);
        bus.wr_en_in = 1'b0;
    endtask

    task automatic write_node(input int addr, input logic [23:0] colour, input int link);
        logic [31:0] w;
        logic [5:0]  l6;
        l6 = link[5:0];
        w = {2'b00, l6, colour};
        for (int l = 0; l < 4; l++) write_bus(addr, 4'b0001 << l, w[l*8 +: 8]);
    endtask

    task automatic request_frame(output int rc);
        @(negedge clk_in);
        bus.frame_rdy_in = 1'b1;
        rc = cyc;
        @(negedge clk_in);
        bus.frame_rdy_in = 1'b0;
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k;
        k = 0;
        while (q_fd.size() < n && k < budget) begin
            @(negedge clk_in); #1;
            k++;
        end
        checks++;
        if (q_fd.size() < n) begin
            errors++;
            $display("FAIL frame_done_wait: got %0d pulses, need %0d within %0d cycles", q_fd.size(), n, budget);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks += 4;
        if (bus.bit_rdy_out !== 1'b0)    begin errors++; $display("FAIL reset_bit_rdy: got %b want 0", bus.bit_rdy_out); end
        if (bus.bit_data_out !== 1'b0)   begin errors++; $display("FAIL reset_bit_data: got %b want 0", bus.bit_data_out); end
        if (bus.busy_out !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
        if (bus.frame_done_out !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done_out); end
        rst_n_in = 1'b1;
        idle_cycles(3);
        checks++;
        if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy_out); end
    endtask

    task automatic test_three_node();
        int rc, n;
        write_node(0, 24'hFF0000, 1);
        write_node(1, 24'h00FF00, 2);
        write_node(2, 24'h0000FF, 0);
        enc_rand = 1'b0; enc_delay = 5;
        build_expected();
        clear_capture();
        request_frame(rc);
        wait_fd(1, 3000);
        idle_cycles(5);
        n = q_bits.size();
        checks += 6;
        if (n != 72) begin errors++; $display("FAIL three_count: got %0d want 72", n); end
        if (count_mismatch(0) != 0) begin errors++; $display("FAIL three_bits: %0d bits differ", count_mismatch(0)); end
        if (q_rdy.size() == 0 || q_rdy[0] != rc + 3 + PIPE) begin errors++; $display("FAIL three_first_latency: got cycle %0d want %0d", (q_rdy.size() > 0) ? q_rdy[0] : -1, rc + 3 + PIPE); end
        if (gap_errors(0, n) != 0) begin errors++; $display("FAIL three_gaps: %0d wrong bit_done->bit_rdy gaps", gap_errors(0, n)); end
        if (q_fd.size() != 1 || q_done.size() == 0 || q_fd[0] != q_done[q_done.size() - 1] + RST_CYCLES + 1) begin
            errors++; $display("FAIL three_fd_timing: pulses %0d first at %0d, last done %0d", q_fd.size(), (q_fd.size() > 0) ? q_fd[0] : -1, (q_done.size() > 0) ? q_done[q_done.size() - 1] : -1);
        end
        if (wide_rdy != 0) begin errors++; $display("FAIL three_rdy_width: %0d multi-cycle bit_rdy pulses", wide_rdy); end
    endtask

    task automatic test_single_node();
        int rc, k, busy_low;
        logic [23:0] got;
        write_node(0, 24'hA5A5A5, 0);
        enc_rand = 1'b1;
        build_expected();
        clear_capture();
        request_frame(rc);
        k = 0; busy_low = 0;
        while (q_fd.size() == 0 && k < 2000) begin
            if (bus.busy_out !== 1'b1) busy_low++;
            @(negedge clk_in); #1;
            k++;
        end
        idle_cycles(10);
        got = '0;
        for (int i = 0; i < 24 && i < q_bits.size(); i++) got[23 - i] = q_bits[i];
        checks += 5;
        if (q_bits.size() != 24) begin errors++; $display("FAIL single_count: got %0d want 24", q_bits.size()); end
        if (got !== 24'hA5A5A5) begin errors++; $display("FAIL single_bits: got %h want a5a5a5", got); end
        if (busy_low != 0) begin errors++; $display("FAIL single_busy: busy low for %0d cycles in frame", busy_low); end
        if (q_fd.size() != 1) begin errors++; $display("FAIL single_fd_count: got %0d want 1", q_fd.size()); end
        if (gap_errors(0, q_bits.size()) != 0) begin errors++; $display("FAIL single_gaps: %0d", gap_errors(0, q_bits.size())); end
    endtask

    task automatic test_cyclic();
        int rc;
        write_node(0, 24'($urandom), 1);
        write_node(1, 24'($urandom), 2);
        write_node(2, 24'($urandom), 1);
        enc_rand = 1'b0; enc_delay = 1;
        build_expected();
        clear_capture();
        request_frame(rc);
        wait_fd(1, 20000);
        checks += 3;
        if (q_bits.size() != 64 * 24) begin errors++; $display("FAIL cyclic_count: got %0d want 1536", q_bits.size()); end
        if (count_mismatch(0) != 0) begin errors++; $display("FAIL cyclic_bits: %0d bits differ", count_mismatch(0)); end
        if (gap_errors(0, q_bits.size()) != 0) begin errors++; $display("FAIL cyclic_gaps: %0d", gap_errors(0, q_bits.size())); end
    endtask

    task automatic test_back_to_back();
        int rc, k, n;
        write_node(0, 24'($urandom), 1);
        write_node(1, 24'($urandom), 2);
        write_node(2, 24'($urandom), 0);
        enc_rand = 1'b0; enc_delay = 2;
        build_expected();
        n = exp_bits.size();
        clear_capture();
        request_frame(rc);
        k = 0;
        while (q_bits.size() < 10 && k < 500) begin @(negedge clk_in); #1; k++; end
        @(negedge clk_in);
        bus.frame_rdy_in = 1'b1;
        @(negedge clk_in);
        bus.frame_rdy_in = 1'b0;
        wait_fd(2, 5000);
        idle_cycles(20);
        checks += 7;
        if (q_bits.size() != 2 * n) begin errors++; $display("FAIL b2b_count: got %0d want %0d", q_bits.size(), 2 * n); end
        if (count_mismatch(0) != 0) begin errors++; $display("FAIL b2b_bits_first: %0d differ", count_mismatch(0)); end
        if (count_mismatch(n) != 0) begin errors++; $display("FAIL b2b_bits_second: %0d differ", count_mismatch(n)); end
        if (q_fd.size() < 1 || q_rdy.size() <= n || q_rdy[n] != q_fd[0] + 3 + PIPE) begin
            errors++; $display("FAIL b2b_restart: second frame first bit at %0d, frame_done at %0d", (q_rdy.size() > n) ? q_rdy[n] : -1, (q_fd.size() > 0) ? q_fd[0] : -1);
        end
        if (q_fd_busy.size() < 1 || q_fd_busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy during frame_done was not 0"); end
        if (gap_errors(0, n) + gap_errors(n, n) != 0) begin errors++; $display("FAIL b2b_gaps: %0d", gap_errors(0, n) + gap_errors(n, n)); end
        if (q_fd.size() != 2) begin errors++; $display("FAIL b2b_fd_count: got %0d want 2", q_fd.size()); end
    endtask

    task automatic test_reset_mid();
        int rc, k;
        bit found;
        write_node(0, 24'($urandom) | 24'h111111, 1);
        write_node(1, 24'($urandom) | 24'h111111, 2);
        write_node(2, 24'($urandom) | 24'h111111, 0);
        enc_rand = 1'b0; enc_delay = 3;
        build_expected();
        clear_capture();
        request_frame(rc);
        k = 0; found = 1'b0;
        while (!found && k < 3000) begin
            @(negedge clk_in); #1;
            if (bus.bit_rdy_out === 1'b1 && bus.bit_data_out === 1'b1 && q_bits.size() >= 30) found = 1'b1;
            else k++;
        end
        #1 rst_n_in = 1'b0;
        #1;
        checks += 4;
        if (!found) begin errors++; $display("FAIL rstmid_setup: no high bit_rdy with data 1 within %0d cycles", k); end
        if (bus.bit_rdy_out !== 1'b0)  begin errors++; $display("FAIL rstmid_bit_rdy: got %b want 0", bus.bit_rdy_out); end
        if (bus.busy_out !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_out); end
        if (bus.bit_data_out !== 1'b0) begin errors++; $display("FAIL rstmid_bit_data: got %b want 0", bus.bit_data_out); end
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        idle_cycles(3);
        clear_capture();
        request_frame(rc);
        wait_fd(1, 3000);
        checks += 3;
        if (q_bits.size() != exp_bits.size()) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", q_bits.size(), exp_bits.size()); end
        if (count_mismatch(0) != 0) begin errors++; $display("FAIL rstmid_bits: %0d differ", count_mismatch(0)); end
        if (q_rdy.size() == 0 || q_rdy[0] != rc + 3 + PIPE) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", (q_rdy.size() > 0) ? q_rdy[0] : -1, rc + 3 + PIPE); end
    endtask

    task automatic test_random();
        int rc, n;
        for (int a = 0; a < DEPTH; a++) write_node(a, 24'($urandom), int'($urandom_range(0, DEPTH - 1)));
        for (int it = 0; it < 2; it++) begin
            for (int w = 0; w < 30; w++) write_bus(int'($urandom_range(0, DEPTH - 1)), 4'($urandom), 8'($urandom));
`ifdef WS2812_DIM_EN
            bus.brightness_in = 8'($urandom);
            bright_model = bus.brightness_in;
`endif
            enc_rand = 1'b1;
            build_expected();
            clear_capture();
            request_frame(rc);
            wait_fd(1, 20000);
            n = q_bits.size();
            checks += 4;
            if (n != exp_bits.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", n, exp_bits.size()); end
            if (count_mismatch(0) != 0) begin errors++; $display("FAIL rand_bits: %0d differ", count_mismatch(0)); end
            if (gap_errors(0, n) != 0) begin errors++; $display("FAIL rand_gaps: %0d", gap_errors(0, n)); end
            if (q_fd.size() < 1 || q_done.size() == 0 || q_fd[0] != q_done[q_done.size() - 1] + RST_CYCLES + 1) begin
                errors++; $display("FAIL rand_fd_timing: frame_done at %0d", (q_fd.size() > 0) ? q_fd[0] : -1);
            end
            idle_cycles(3);
        end
    endtask

`ifdef WS2812_DIM_EN
    task automatic test_dim();
        int rc;
        logic [23:0] got;
        write_node(0, 24'hFF8040, 0);
        bus.brightness_in = 8'h7F;
        bright_model = 8'h7F;
        enc_rand = 1'b0; enc_delay = 2;
        clear_capture();
        request_frame(rc);
        wait_fd(1, 2000);
        got = '0;
        for (int i = 0; i < 24 && i < q_bits.size(); i++) got[23 - i] = q_bits[i];
        checks += 2;
        if (got !== 24'h7F4020) begin errors++; $display("FAIL dim_bits: got %h want 7f4020", got); end
        if (q_rdy.size() == 0 || q_rdy[0] != rc + 4) begin errors++; $display("FAIL dim_latency: got %0d want %0d", (q_rdy.size() > 0) ? q_rdy[0] : -1, rc + 4); end
    endtask
`endif

    initial begin
        errors = 0; checks = 0;
        enc_rand = 1'b0; enc_delay = 5; wide_rdy = 0;
        rst_n_in = 1'b0;
        bus.wr_en_in = 1'b0; bus.wr_addr_in = '0; bus.wr_byte_en_in = '0; bus.wr_data_in = '0;
        bus.frame_rdy_in = 1'b0;
`ifdef WS2812_DIM_EN
        bus.brightness_in = 8'hFF;
        bright_model = 8'hFF;
`endif
        for (int a = 0; a < DEPTH; a++) mem_model[a] = '0;
        test_reset();
        test_three_node();
        test_single_node();
        test_cyclic();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef WS2812_DIM_EN
        test_dim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
